// File: rtl/sc_statemachine_countdown_if.sv
// rtl/sc_statemachine_countdown_if.sv - control inputs and display outputs of the countdown block
interface sc_statemachine_countdown_if;
  logic       SC_STATEMACHINECOUNTDOWN_SENALREGRESIVA;
  logic       SC_STATEMACHINECOUNTDOWN_PAUSE_InLow;
  logic       SC_STATEMACHINECOUNTDOWN_ABORT_InLow;
  logic [3:0] SC_STATEMACHINECOUNTDOWN_DIGIT;
  logic       SC_STATEMACHINECOUNTDOWN_ACTIVE;
  logic       SC_STATEMACHINECOUNTDOWN_GO;
  logic [6:0] SC_STATEMACHINECOUNTDOWN_SEVENSEG;

  modport master (
    output SC_STATEMACHINECOUNTDOWN_SENALREGRESIVA,
    output SC_STATEMACHINECOUNTDOWN_PAUSE_InLow,
    output SC_STATEMACHINECOUNTDOWN_ABORT_InLow,
    input  SC_STATEMACHINECOUNTDOWN_DIGIT,
    input  SC_STATEMACHINECOUNTDOWN_ACTIVE,
    input  SC_STATEMACHINECOUNTDOWN_GO,
    input  SC_STATEMACHINECOUNTDOWN_SEVENSEG
  );

  modport slave (
    input  SC_STATEMACHINECOUNTDOWN_SENALREGRESIVA,
    input  SC_STATEMACHINECOUNTDOWN_PAUSE_InLow,
    input  SC_STATEMACHINECOUNTDOWN_ABORT_InLow,
    output SC_STATEMACHINECOUNTDOWN_DIGIT,
    output SC_STATEMACHINECOUNTDOWN_ACTIVE,
    output SC_STATEMACHINECOUNTDOWN_GO,
    output SC_STATEMACHINECOUNTDOWN_SEVENSEG
  );
endinterface

// File: rtl/sc_statemachine_countdown.sv
// rtl/sc_statemachine_countdown.sv - prescaled START_VALUE..0 countdown with GO pulse and 7-seg digit
module sc_statemachine_countdown #(
  parameter int TICK_DIV        = 50000000,
  parameter int START_VALUE     = 3,
  parameter int PRESCALER_WIDTH = 26
) (
  input  logic                      SC_STATEMACHINECOUNTDOWN_CLOCK_50,
  input  logic                      SC_STATEMACHINECOUNTDOWN_RESET_InLow,
  sc_statemachine_countdown_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_GO, S_HOLD} state_t;

  localparam logic [PRESCALER_WIDTH-1:0] TERM  = PRESCALER_WIDTH'(TICK_DIV - 1);
  localparam logic [PRESCALER_WIDTH-1:0] PONE  = PRESCALER_WIDTH'(1);
  localparam logic [3:0]                 START = 4'(START_VALUE);

  state_t                     state, state_n;
  logic [PRESCALER_WIDTH-1:0] pre, pre_n;
  logic [3:0]                 digit, digit_n;
  logic                       prev;
  logic                       rise;
  logic [6:0]                 seg;

  assign rise = bus.SC_STATEMACHINECOUNTDOWN_SENALREGRESIVA & ~prev;

  // prev resets high so a level already asserted at reset release is not a start
  always_ff @(posedge SC_STATEMACHINECOUNTDOWN_CLOCK_50 or negedge SC_STATEMACHINECOUNTDOWN_RESET_InLow) begin
    if (!SC_STATEMACHINECOUNTDOWN_RESET_InLow) begin
      state <= S_IDLE;
      pre   <= '0;
      digit <= '0;
      prev  <= 1'b1;
    end else begin
      state <= state_n;
      pre   <= pre_n;
      digit <= digit_n;
      prev  <= bus.SC_STATEMACHINECOUNTDOWN_SENALREGRESIVA;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    digit_n = digit;
    if (!bus.SC_STATEMACHINECOUNTDOWN_ABORT_InLow) begin
      state_n = S_IDLE;
      pre_n   = '0;
      digit_n = '0;
    end else if (bus.SC_STATEMACHINECOUNTDOWN_PAUSE_InLow) begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            pre_n = '0;
            if (START_VALUE > 0) begin
              state_n = S_COUNT;
              digit_n = START;
            end else begin
              state_n = S_GO;
              digit_n = '0;
            end
          end
        end
        S_COUNT: begin
          if (pre == TERM) begin
            pre_n = '0;
            if (digit > 4'd1) begin
              digit_n = digit - 4'd1;
            end else begin
              digit_n = '0;
              state_n = S_GO;
            end
          end else begin
            pre_n = pre + PONE;
          end
        end
        S_GO: begin
          state_n = S_HOLD;
          pre_n   = '0;
          digit_n = '0;
        end
        S_HOLD: begin
          if (pre == TERM) begin
            state_n = S_IDLE;
            pre_n   = '0;
            digit_n = '0;
          end else begin
            pre_n = pre + PONE;
          end
        end
        default: begin
          state_n = S_IDLE;
          pre_n   = '0;
          digit_n = '0;
        end
      endcase
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

  assign bus.SC_STATEMACHINECOUNTDOWN_DIGIT    = digit;
  assign bus.SC_STATEMACHINECOUNTDOWN_ACTIVE   = (state != S_IDLE);
  assign bus.SC_STATEMACHINECOUNTDOWN_GO       = (state == S_GO);
  assign bus.SC_STATEMACHINECOUNTDOWN_SEVENSEG = (state == S_IDLE) ? 7'b1111111 : seg;

endmodule
